// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, GF(2^8) arithmetic, ShiftRows byte map and FSM states.
// Used by aes_sbox and aes_round_engine.
package aes_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } aes_fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte i = row (i % 4), column (i / 4); ShiftRows output byte i takes this input byte.
    localparam int unsigned SHIFT_SRC [16] = '{
        0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] result
);

    assign result = SBOX[value];

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES encryption engine: one full round per clock, valid/ready on both sides.
// Optional macro AES_KEY_LATCH_EN captures the key schedule on acceptance.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [(Nr+1)*128-1:0] words,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          plaintext,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          ciphertext
);

    localparam int unsigned KeyW = (Nr + 1) * 128;
    localparam logic [3:0]  NrCnt = 4'(Nr);

    if (Nr != Nk + 6) begin : gen_cfg_check
        $error("aes_round_engine: Nr must equal Nk + 6");
    end

    aes_fsm_e     fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] state_q, state_d;
    logic [KeyW-1:0] key_src;

`ifdef AES_KEY_LATCH_EN
    logic [KeyW-1:0] key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
        end else if (fsm_q == StIdle && in_valid) begin
            key_q <= words;
        end
    end

    assign key_src = key_q;
`else
    assign key_src = words;
`endif

    logic [127:0] round_keys [Nr+1];
    for (genvar r = 0; r <= Nr; r++) begin : gen_rk
        assign round_keys[r] = key_src[(Nr - r) * 128 +: 128];
    end

    logic [7:0] st_byte    [16];
    logic [7:0] sub_byte   [16];
    logic [7:0] shift_byte [16];
    logic [7:0] mix_byte   [16];

    for (genvar i = 0; i < 16; i++) begin : gen_sub
        assign st_byte[i] = state_q[127 - 8*i -: 8];
        aes_sbox u_sbox (
            .value  (st_byte[i]),
            .result (sub_byte[i])
        );
        assign shift_byte[i] = sub_byte[SHIFT_SRC[i]];
    end

    for (genvar c = 0; c < 4; c++) begin : gen_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = shift_byte[4*c];
        assign a1 = shift_byte[4*c+1];
        assign a2 = shift_byte[4*c+2];
        assign a3 = shift_byte[4*c+3];
        assign mix_byte[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
        assign mix_byte[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
        assign mix_byte[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
        assign mix_byte[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
    end

    logic         last_round;
    logic [127:0] round_key;
    logic [127:0] round_out;

    assign last_round = (cnt_q == NrCnt);
    assign round_key  = round_keys[cnt_q];

    always_comb begin
        round_out = '0;
        for (int i = 0; i < 16; i++) begin
            round_out[127 - 8*i -: 8] = (last_round ? shift_byte[i] : mix_byte[i])
                                        ^ round_key[127 - 8*i -: 8];
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Round key 0 comes straight from the port in both build variants.
                    state_d = plaintext ^ words[KeyW-1 -: 128];
                    cnt_d   = 4'd1;
                    fsm_d   = StRun;
                end
            end
            StRun: begin
                state_d = round_out;
                if (last_round) begin
                    fsm_d = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) fsm_d = StIdle;
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= StIdle;
            cnt_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign ciphertext = state_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine with AES-128 and AES-256 instances.
// Also exercises the AES_KEY_LATCH_EN build when that macro is defined.
module tb_aes_round_engine;
    import aes_pkg::*;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [1407:0] words128;
    logic          in_valid128, in_ready128, out_valid128, out_ready128;
    logic [127:0]  pt128, ct128;

    logic [1919:0] words256;
    logic          in_valid256, in_ready256, out_valid256, out_ready256;
    logic [127:0]  pt256, ct256;

    logic [1919:0] sched128, sched256;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_round_engine #(.Nk(4), .Nr(10)) dut128 (
        .clk        (clk),
        .rst_n      (rst_n),
        .words      (words128),
        .in_valid   (in_valid128),
        .in_ready   (in_ready128),
        .plaintext  (pt128),
        .out_valid  (out_valid128),
        .out_ready  (out_ready128),
        .ciphertext (ct128)
    );

    aes_round_engine #(.Nk(8), .Nr(14)) dut256 (
        .clk        (clk),
        .rst_n      (rst_n),
        .words      (words256),
        .in_valid   (in_valid256),
        .in_ready   (in_ready256),
        .plaintext  (pt256),
        .out_valid  (out_valid256),
        .out_ready  (out_ready256),
        .ciphertext (ct256)
    );

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // FIPS-197 key expansion; w0 lands in the top 32 bits of the result.
    function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk,
                                                 input int nr);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] sched;
        rcon  = 8'h01;
        sched = '0;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t    = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subword(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            sched[1919 - 32*i -: 32] = w[i];
        end
        return sched;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (in_ready128 !== 1'b1 || out_valid128 !== 1'b0 || ct128 !== 128'h0) begin
            errors++;
            $display("FAIL reset128: in_ready=%b out_valid=%b ct=%h, want 1 0 0",
                     in_ready128, out_valid128, ct128);
        end
        checks++;
        if (in_ready256 !== 1'b1 || out_valid256 !== 1'b0 || ct256 !== 128'h0) begin
            errors++;
            $display("FAIL reset256: in_ready=%b out_valid=%b ct=%h, want 1 0 0",
                     in_ready256, out_valid256, ct256);
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_aes128();
        int edges;
        pt128 = PT;
        out_ready128 = 1'b1;
        in_valid128 = 1'b1;
        tick();
        in_valid128 = 1'b0;
        edges = 1;
        checks++;
        if (in_ready128 !== 1'b0) begin
            errors++;
            $display("FAIL run128_in_ready: got %b want 0", in_ready128);
        end
        while (out_valid128 !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        checks++;
        if (edges != 11) begin
            errors++;
            $display("FAIL latency128: got %0d edges want 11", edges);
        end
        checks++;
        if (ct128 !== CT128) begin
            errors++;
            $display("FAIL ct128: got %h want %h", ct128, CT128);
        end
        tick();
        checks++;
        if (out_valid128 !== 1'b0 || in_ready128 !== 1'b1) begin
            errors++;
            $display("FAIL handoff128: out_valid=%b in_ready=%b want 0 1",
                     out_valid128, in_ready128);
        end
    endtask

    task automatic test_aes256();
        int edges;
        pt256 = PT;
        out_ready256 = 1'b1;
        in_valid256 = 1'b1;
        tick();
        in_valid256 = 1'b0;
        edges = 1;
        while (out_valid256 !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        checks++;
        if (edges != 15) begin
            errors++;
            $display("FAIL latency256: got %0d edges want 15", edges);
        end
        checks++;
        if (ct256 !== CT256) begin
            errors++;
            $display("FAIL ct256: got %h want %h", ct256, CT256);
        end
        tick();
        checks++;
        if (out_valid256 !== 1'b0 || in_ready256 !== 1'b1) begin
            errors++;
            $display("FAIL handoff256: out_valid=%b in_ready=%b want 0 1",
                     out_valid256, in_ready256);
        end
    endtask

    task automatic test_stall();
        int edges;
        pt128 = PT;
        out_ready128 = 1'b0;
        in_valid128 = 1'b1;
        tick();
        in_valid128 = 1'b0;
        edges = 1;
        while (out_valid128 !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        for (int i = 0; i < 20; i++) begin
            in_valid128 = i[0];
            tick();
            checks++;
            if (out_valid128 !== 1'b1 || in_ready128 !== 1'b0 || ct128 !== CT128) begin
                errors++;
                $display("FAIL stall[%0d]: out_valid=%b in_ready=%b ct=%h want 1 0 %h",
                         i, out_valid128, in_ready128, ct128, CT128);
            end
        end
        in_valid128 = 1'b0;
        out_ready128 = 1'b1;
        tick();
        checks++;
        if (out_valid128 !== 1'b0 || in_ready128 !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b want 0 1",
                     out_valid128, in_ready128);
        end
        tick();
        checks++;
        if (in_ready128 !== 1'b1) begin
            errors++;
            $display("FAIL stall_no_ghost: in_ready=%b want 1", in_ready128);
        end
    endtask

    task automatic test_reset_mid_run();
        pt128 = PT;
        out_ready128 = 1'b1;
        in_valid128 = 1'b1;
        tick();
        in_valid128 = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready128 !== 1'b1 || out_valid128 !== 1'b0 || ct128 !== 128'h0) begin
            errors++;
            $display("FAIL midrun_reset: in_ready=%b out_valid=%b ct=%h want 1 0 0",
                     in_ready128, out_valid128, ct128);
        end
        tick();
        rst_n = 1'b1;
        test_aes128();
    endtask

    task automatic test_key_latch();
        int edges;
        pt128 = PT;
        out_ready128 = 1'b1;
        in_valid128 = 1'b1;
        tick();
        in_valid128 = 1'b0;
        edges = 1;
`ifdef AES_KEY_LATCH_EN
        tick();
        edges++;
        words128 = '0;
`endif
        while (out_valid128 !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        checks++;
        if (out_valid128 !== 1'b1 || ct128 !== CT128) begin
            errors++;
            $display("FAIL key_latch: out_valid=%b ct=%h want 1 %h", out_valid128, ct128, CT128);
        end
        tick();
        words128 = sched128[1919 -: 1408];
    endtask

    task automatic test_back_to_back();
        int           acc [$];
        logic [127:0] outs [$];
        int           waited;
        pt128 = PT;
        out_ready128 = 1'b1;
        in_valid128 = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (in_ready128 === 1'b1) acc.push_back(cyc);
            if (out_valid128 === 1'b1) outs.push_back(ct128);
            tick();
        end
        in_valid128 = 1'b0;
        checks++;
        if (acc.size() < 2) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d acceptances want at least 2", acc.size());
        end else if (acc[1] - acc[0] != 12) begin
            errors++;
            $display("FAIL b2b_period: got %0d cycles want 12", acc[1] - acc[0]);
        end
        checks++;
        if (outs.size() < 2) begin
            errors++;
            $display("FAIL b2b_outputs: got %0d results want at least 2", outs.size());
        end else if (outs[0] !== CT128 || outs[1] !== CT128) begin
            errors++;
            $display("FAIL b2b_ct: got %h %h want %h", outs[0], outs[1], CT128);
        end
        waited = 0;
        while (in_ready128 !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        checks++;
        if (in_ready128 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain: in_ready=%b want 1", in_ready128);
        end
    endtask

    initial begin
        sched128 = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        sched256 = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                              8, 14);
        words128 = sched128[1919 -: 1408];
        words256 = sched256;
        in_valid128 = 1'b0;
        in_valid256 = 1'b0;
        out_ready128 = 1'b1;
        out_ready256 = 1'b1;
        pt128 = '0;
        pt256 = '0;

        test_reset();
        test_aes128();
        test_aes256();
        test_stall();
        test_reset_mid_run();
        test_key_latch();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_engine.md
AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

Interface
REQ-001 SHALL have parameter Nk, default 4, meaning key length in 32-bit words (4, 6 or 8).
REQ-002 SHALL have parameter Nr, default 10, meaning number of cipher rounds (10, 12 or 14).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-005 SHALL have port words, input, (Nr+1)*128 bits, meaning the expanded key schedule: w0 in the top 32 bits, w(4(Nr+1)-1) in the bottom 32 bits; round key r is w(4r)..w(4r+3).
REQ-006 SHALL have port in_valid, input, 1 bit, meaning the plaintext is valid.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the engine accepts a block.
REQ-008 SHALL have port plaintext, input, 128 bits, meaning the input block; byte 0 is in bits [127:120], in column-major state order.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning the ciphertext is valid.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning downstream accepts the ciphertext.
REQ-011 SHALL have port ciphertext, output, 128 bits, meaning the result block, in the same byte order as plaintext.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE, in_ready SHALL be 1; in_valid&&in_ready SHALL load state = plaintext XOR round key 0, set round counter to 1, and move to RUN.
REQ-014 In RUN, SHALL perform one full round per cycle: SubBytes, ShiftRows, MixColumns (omitted when counter==Nr), then AddRoundKey(counter); counter increments by 1.
REQ-015 After the round with counter==Nr, SHALL move to DONE; out_valid SHALL be 1 exactly from the (Nr+1)th edge after acceptance.
REQ-016 In DONE, ciphertext SHALL hold the state stable until out_valid&&out_ready, then SHALL return to IDLE; in_ready SHALL be 0 in RUN and DONE.
REQ-017 SHALL accept no new block in the cycle of ciphertext handoff; the back-to-back period is Nr+2 cycles.
REQ-018 The round counter SHALL be 4 bits wide and never exceed Nr; in_valid while busy SHALL be ignored and SHALL NOT be dropped, because in_ready is 0.
REQ-019 out_ready held low SHALL stall in DONE indefinitely with no data change.

Reset
REQ-020 rst_n low SHALL immediately force IDLE, counter 0, state 0, in_ready 1, out_valid 0 and ciphertext 0, including mid-RUN; the aborted block SHALL be discarded.
REQ-021 The first acceptance after rst_n deasserts SHALL be possible on the first rising edge.

Configuration
REQ-022 With macro AES_KEY_LATCH_EN defined, words SHALL be captured into an internal register on acceptance, and rounds SHALL use the captured copy, so words may change freely after acceptance.
REQ-023 Without AES_KEY_LATCH_EN, no key register SHALL exist, and words SHALL be held stable by the source from acceptance until out_valid; the results are otherwise identical.

Structure
REQ-024 Shared package aes_pkg SHALL hold the S-box table, the xtime/GF(2^8) multiply functions, the state byte-index constants and the FSM state typedef.
REQ-025 SHALL instantiate 16 copies of sub-module aes_sbox (8-bit in, 8-bit out, combinational) for SubBytes; ShiftRows/MixColumns SHALL be inline logic.

Verification
REQ-026 Nk=4,Nr=10; key 000102..0f schedule, plaintext 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 11 cycles after accept.
REQ-027 Nk=8,Nr=14; key 000102..1f, same plaintext -> 8ea2b7ca516745bfeafc49904b496089 after 15 cycles.
REQ-028 out_ready low for 20 cycles in DONE -> ciphertext and out_valid stable, in_ready 0, and in_valid pulses ignored.
REQ-029 rst_n pulsed at round 5 -> outputs 0 immediately; a following block yields the correct ciphertext.
REQ-030 With AES_KEY_LATCH_EN, words changed to all-zero one cycle after accept -> result still 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-031 Two blocks with continuous in_valid and out_ready=1 -> acceptances exactly 12 cycles apart (Nr=10).
